full_add4: RTL and testbench
============================

// Module: full_add4
// PURPOSE
// - 4-bit ripple-carry adder (A + B + C_IN) with registered SUM/C_OUT, built from 1-bit full-adder cells.
// - Sits in the datapath as the basic carry-in/carry-out add stage; cascadable via C_IN/C_OUT.
// - Adds an input-valid/output-valid qualifier and a signed-overflow flag so the registered result can be consumed by downstream stages.
// PARAMETERS
// - WIDTH    default 4   operand/sum width; must be >= 1; all behaviour below is stated for WIDTH=4
// PORTS
// - clk       in   1      single clock, all state updates on rising edge
// - rst_n     in   1      reset: synchronous, active-low
// - in_valid  in   1      operands A/B/C_IN qualified this cycle
// - A         in   WIDTH  operand A, unsigned (also read as two's complement for ovf)
// - B         in   WIDTH  operand B
// - C_IN      in   1      carry in (LSB)
// - SUM       out  WIDTH  registered sum bits
// - C_OUT     out  1      registered carry out of MSB
// - ovf       out  1      registered two's-complement overflow: carry into MSB XOR carry out of MSB
// - out_valid out  1      SUM/C_OUT/ovf hold a result captured on the previous edge
// BEHAVIOUR
// - Reset: on rising clk with rst_n=0 -> SUM=0, C_OUT=0, ovf=0, out_valid=0. Overrides in_valid the same edge.
// - Combinational core: WIDTH chained full-adder cells; cell i: s=a^b^c, co=(a&b)|(c&(a^b)); c[0]=C_IN.
// - Arithmetic: {C_OUT,SUM} = A + B + C_IN, exact, (WIDTH+1) bits, no truncation of carry.
// - Latency: 1 cycle. Edge with rst_n=1 and in_valid=1 -> capture SUM/C_OUT/ovf, out_valid=1.
// - Edge with rst_n=1 and in_valid=0 -> SUM/C_OUT/ovf hold last value; out_valid=0.
// - Back-to-back: in_valid may be 1 every cycle; full throughput, one result per cycle, no stall/backpressure.
// - Unknown/X inputs while in_valid=0 must not disturb held outputs.
// - Boundary: all-ones + 0 + C_IN=1 -> SUM=0, C_OUT=1 (wrap-around); 0+0+0 -> all zero.
// - ovf independent of C_OUT: e.g. 4+5 sets ovf=1, C_OUT=0; 15+1 sets C_OUT=1, ovf=0.
// - Reset asserted mid-stream discards the in-flight capture; first valid result after reset release appears 1 cycle after first in_valid.
// - No combinational path from inputs to outputs.
// TESTING
// - Reset: hold rst_n=0 2 cycles with in_valid=1, A=4'hF -> SUM=0, C_OUT=0, ovf=0, out_valid=0.
// - A=0,B=0,C_IN=0,in_valid=1 -> next cycle SUM=0000, C_OUT=0, ovf=0, out_valid=1.
// - Sequence A/B = 1/2, 2/3, 4/5, 6/7 with C_IN=0 each cycle -> SUM 0011, 0101, 1001(ovf=1), 1101(ovf=1), C_OUT=0, one cycle later each.
// - A=4'hF,B=4'h0,C_IN=1 -> SUM=0000, C_OUT=1, ovf=0; A=4'h8,B=4'h8,C_IN=0 -> SUM=0000, C_OUT=1, ovf=1.
// - Hold: load 6+7, then in_valid=0 with A/B changing -> SUM stays 1101, out_valid drops to 0.
// - Exhaustive: all 512 (A,B,C_IN) combos back-to-back vs reference model A+B+C_IN and ovf rule, 1-cycle lag.

Source files
------------

// File: rtl/full_add4.sv
// Ripple-carry adder built from chained full-adder cells, with registered
// SUM/C_OUT/ovf and a one-cycle valid qualifier.
module full_add4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_IN,
  output logic [WIDTH-1:0] SUM,
  output logic             C_OUT,
  output logic             ovf,
  output logic             out_valid
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_comb;

  logic [WIDTH-1:0] sum_d,       sum_q;
  logic             c_out_d,     c_out_q;
  logic             ovf_d,       ovf_q;
  logic             out_valid_d, out_valid_q;

  assign carry[0] = C_IN;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign sum_comb[i] = A[i] ^ B[i] ^ carry[i];
    assign carry[i+1]  = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
  end

  // Results only load on a qualified cycle, so unqualified (even X) operands never reach the flops.
  always_comb begin
    sum_d       = sum_q;
    c_out_d     = c_out_q;
    ovf_d       = ovf_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      sum_d   = sum_comb;
      c_out_d = carry[WIDTH];
      ovf_d   = carry[WIDTH] ^ carry[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q       <= '0;
      c_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      c_out_q     <= c_out_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign SUM       = sum_q;
  assign C_OUT     = c_out_q;
  assign ovf       = ovf_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_full_add4.sv
// Scoreboard bench for full_add4: stimulus pushes hand-computed or modelled
// results, a negedge monitor pops and compares whenever out_valid is high.
module tb_full_add4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] a_in = 4'h0;
  logic [3:0] b_in = 4'h0;
  logic       c_in = 1'b0;
  logic [3:0] sum;
  logic       c_out, ovf, out_valid;

  typedef struct packed {
    logic [3:0] sum;
    logic       c_out;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  full_add4 #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .A(a_in), .B(b_in), .C_IN(c_in),
    .SUM(sum), .C_OUT(c_out), .ovf(ovf), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Drives one cycle of operands (called #1 after a rising edge) and queues the expected result.
  task automatic apply_stimulus(input logic [3:0] a, input logic [3:0] b, input logic cin,
                                input logic valid, input logic [3:0] e_sum,
                                input logic e_cout, input logic e_ovf);
    exp_t e;
    a_in = a;
    b_in = b;
    c_in = cin;
    in_valid = valid;
    if (valid && rst_n) begin
      e.sum = e_sum;
      e.c_out = e_cout;
      e.ovf = e_ovf;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_out_valid: got out_valid=1 with sum=%0h, required no result", sum);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_output("sum", {4'h0, sum}, {4'h0, e.sum});
        check_output("c_out", {7'h0, c_out}, {7'h0, e.c_out});
        check_output("ovf", {7'h0, ovf}, {7'h0, e.ovf});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required test completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [8:0] v;
    logic [4:0] s;
    int         sa, sb, ss;

    // Reset held two edges while a valid all-ones operand is presented
    rst_n = 1'b0;
    in_valid = 1'b1;
    a_in = 4'hF;
    b_in = 4'h1;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_sum", {4'h0, sum}, 8'h00);
    check_output("reset_c_out", {7'h0, c_out}, 8'h00);
    check_output("reset_ovf", {7'h0, ovf}, 8'h00);
    check_output("reset_out_valid", {7'h0, out_valid}, 8'h00);
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_output("idle_out_valid", {7'h0, out_valid}, 8'h00);

    apply_stimulus(4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0);
    apply_stimulus(4'h1, 4'h2, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0);
    apply_stimulus(4'h2, 4'h3, 1'b0, 1'b1, 4'h5, 1'b0, 1'b0);
    apply_stimulus(4'h4, 4'h5, 1'b0, 1'b1, 4'h9, 1'b0, 1'b1);
    apply_stimulus(4'h6, 4'h7, 1'b0, 1'b1, 4'hD, 1'b0, 1'b1);
    apply_stimulus(4'hF, 4'h0, 1'b1, 1'b1, 4'h0, 1'b1, 1'b0);
    apply_stimulus(4'h8, 4'h8, 1'b0, 1'b1, 4'h0, 1'b1, 1'b1);
    apply_stimulus(4'hF, 4'h1, 1'b0, 1'b1, 4'h0, 1'b1, 1'b0);
    apply_stimulus(4'h7, 4'h7, 1'b1, 1'b1, 4'hF, 1'b0, 1'b1);

    // Hold: load 6+7, then change operands without in_valid
    apply_stimulus(4'h6, 4'h7, 1'b0, 1'b1, 4'hD, 1'b0, 1'b1);
    apply_stimulus(4'hA, 4'h3, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    check_output("hold_sum", {4'h0, sum}, 8'h0D);
    check_output("hold_c_out", {7'h0, c_out}, 8'h00);
    check_output("hold_ovf", {7'h0, ovf}, 8'h01);
    check_output("hold_out_valid", {7'h0, out_valid}, 8'h00);
    apply_stimulus(4'hx, 4'hx, 1'bx, 1'b0, 4'h0, 1'b0, 1'b0);
    check_output("hold_x_sum", {4'h0, sum}, 8'h0D);
    check_output("hold_x_ovf", {7'h0, ovf}, 8'h01);

    // Reset on the same edge as a valid operand discards it
    rst_n = 1'b0;
    apply_stimulus(4'h3, 4'h3, 1'b0, 1'b1, 4'h6, 1'b0, 1'b0);
    check_output("midreset_out_valid", {7'h0, out_valid}, 8'h00);
    check_output("midreset_sum", {4'h0, sum}, 8'h00);
    rst_n = 1'b1;
    apply_stimulus(4'h1, 4'h1, 1'b1, 1'b1, 4'h3, 1'b0, 1'b0);
    check_output("post_reset_out_valid", {7'h0, out_valid}, 8'h01);

    // Exhaustive back-to-back sweep against an integer reference model
    for (int i = 0; i < 512; i++) begin
      v  = i[8:0];
      s  = {1'b0, v[3:0]} + {1'b0, v[7:4]} + {4'h0, v[8]};
      sa = v[3] ? int'(v[3:0]) - 16 : int'(v[3:0]);
      sb = v[7] ? int'(v[7:4]) - 16 : int'(v[7:4]);
      ss = sa + sb + int'(v[8]);
      apply_stimulus(v[3:0], v[7:4], v[8], 1'b1, s[3:0], s[4], (ss > 7) || (ss < -8));
    end

    repeat (3) apply_stimulus(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    check_output("scoreboard_drained", exp_q.size() == 0 ? 8'h01 : 8'h00, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
